// File: rtl/time_keeper.sv
// ---------------------------------------------------------------------------
// time_keeper
//   12-hour clock with AM/PM flag, driven by a single clock and two raw
//   set buttons (hour, minute). Each button is synchronized, debounced and
//   fed to a small IDLE/HELD/REPEAT set machine that issues one increment
//   on press and auto-repeats while held. Normal timekeeping is frozen for
//   as long as either debounced button is down.
//
// Ports
//   clk_in    in   1  only clock
//   reset_n   in   1  asynchronous active-low reset
//   btn_hr    in   1  raw hour-set button, active-high
//   btn_min   in   1  raw minute-set button, active-high
//   hours     out  4  binary hour 1..12
//   min_tens  out  4  BCD minute tens 0..5
//   min_ones  out  4  BCD minute ones 0..9
//   sec       out  6  binary seconds 0..59
//   pm        out  1  1 = PM, 0 = AM
//   sec_tick  out  1  one-cycle pulse per second boundary
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// time_keeper_btn
//   One button channel: 2-flop synchronizer, debounce counter and set FSM.
//
// Ports
//   clk_in      in   1  clock
//   reset_n     in   1  asynchronous active-low reset
//   btn         in   1  raw asynchronous button
//   level       out  1  registered debounced level
//   level_next  out  1  value level takes at the next edge
//   inc         out  1  registered one-cycle increment request
// ---------------------------------------------------------------------------
module time_keeper_btn #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic clk_in,
   input  logic reset_n,
   input  logic btn,
   output logic level,
   output logic level_next,
   output logic inc
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t          state, state_n;
   logic            sync_p0, sync_p1;
   logic [DW-1:0]   db_cnt, db_cnt_n;
   logic [RW-1:0]   rpt_cnt, rpt_cnt_n;
   logic            inc_n;

   // ---- stage p0/p1: two-flop synchronizer ----
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
      end
   end

   // ---- debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive
   //      disagreeing cycle; any agreeing cycle restarts the count ----
   always_comb begin
      level_next = level;
      db_cnt_n   = '0;
      if (sync_p1 != level) begin
         if (db_cnt == DB_LAST) begin
            level_next = sync_p1;
         end else begin
            db_cnt_n = db_cnt + DW'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         level  <= 1'b0;
         db_cnt <= '0;
      end else begin
         level  <= level_next;
         db_cnt <= db_cnt_n;
      end
   end

   // ---- set FSM: level is already registered, so "level high while IDLE"
   //      is exactly the debounced rising edge ----
   always_comb begin
      state_n   = state;
      rpt_cnt_n = rpt_cnt;
      inc_n     = 1'b0;
      case (state)
         IDLE: begin
            rpt_cnt_n = '0;
            if (level) begin
               state_n = HELD;
               inc_n   = 1'b1;
            end
         end
         HELD, REPEAT: begin
            if (!level) begin
               state_n   = IDLE;
               rpt_cnt_n = '0;
            end else if (rpt_cnt == RPT_LAST) begin
               state_n   = REPEAT;
               inc_n     = 1'b1;
               rpt_cnt_n = '0;
            end else begin
               rpt_cnt_n = rpt_cnt + RW'(1);
            end
         end
         default: begin
            state_n   = IDLE;
            rpt_cnt_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         rpt_cnt <= '0;
         inc     <= 1'b0;
      end else begin
         state   <= state_n;
         rpt_cnt <= rpt_cnt_n;
         inc     <= inc_n;
      end
   end

endmodule

module time_keeper #(
   parameter int CLK_HZ          = 100000000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic       clk_in,
   input  logic       reset_n,
   input  logic       btn_hr,
   input  logic       btn_min,
   output logic [3:0] hours,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [5:0] sec,
   output logic       pm,
   output logic       sec_tick
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

   logic          hr_level, hr_level_next, hr_inc;
   logic          min_level, min_level_next, min_inc;
   logic          pressed, press_next, min_apply;
   logic [PW-1:0] presc, presc_n;
   logic          sec_tick_n;
   logic [3:0]    hours_n, min_tens_n, min_ones_n;
   logic [5:0]    sec_n;
   logic          pm_n;
   logic [8:0]    mstep;

   // Returns {pm, hours}: 12 wraps to 1, 11->12 flips AM/PM. Anything at or
   // above 12 lands on 1 so a corrupted value cannot persist.
   function automatic logic [4:0] hour_step(input logic [3:0] h, input logic p);
      logic [3:0] h_n;
      logic       p_n;
      h_n = h + 4'd1;
      p_n = p;
      if (h >= 4'd12) begin
         h_n = 4'd1;
      end else if (h == 4'd11) begin
         p_n = ~p;
      end
      return {p_n, h_n};
   endfunction

   // Returns {carry, tens, ones} for a BCD minute increment; 59 -> 00 carries.
   function automatic logic [8:0] min_step(input logic [3:0] t, input logic [3:0] o);
      logic [3:0] t_n;
      logic [3:0] o_n;
      logic       c;
      t_n = t;
      o_n = o + 4'd1;
      c   = 1'b0;
      if (o >= 4'd9) begin
         o_n = 4'd0;
         if (t >= 4'd5) begin
            t_n = 4'd0;
            c   = 1'b1;
         end else begin
            t_n = t + 4'd1;
         end
      end
      return {c, t_n, o_n};
   endfunction

   time_keeper_btn #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_hr (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .btn        (btn_hr),
      .level      (hr_level),
      .level_next (hr_level_next),
      .inc        (hr_inc)
   );

   time_keeper_btn #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_min (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .btn        (btn_min),
      .level      (min_level),
      .level_next (min_level_next),
      .inc        (min_inc)
   );

   assign pressed    = hr_level | min_level;
   assign press_next = hr_level_next | min_level_next;
   // Hour wins a same-cycle collision; the minute request is dropped.
   assign min_apply  = min_inc & ~hr_inc;

   // ---- prescaler: cleared using the debounced level as it is being
   //      loaded, so sec_tick can never be high while a button reads down ----
   always_comb begin
      if (press_next || min_apply) begin
         presc_n = '0;
      end else if (presc == PRESC_LAST) begin
         presc_n = '0;
      end else begin
         presc_n = presc + PW'(1);
      end
      sec_tick_n = (presc_n == PRESC_LAST) && !press_next;
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         presc    <= '0;
         sec_tick <= 1'b0;
      end else begin
         presc    <= presc_n;
         sec_tick <= sec_tick_n;
      end
   end

   // ---- time registers: set increments take priority over the tick ----
   always_comb begin
      hours_n    = hours;
      pm_n       = pm;
      min_tens_n = min_tens;
      min_ones_n = min_ones;
      sec_n      = sec;
      mstep      = min_step(min_tens, min_ones);
      if (hr_inc) begin
         {pm_n, hours_n} = hour_step(hours, pm);
      end else if (min_apply) begin
         {min_tens_n, min_ones_n} = mstep[7:0];
         sec_n = 6'd0;
      end else if (sec_tick && !pressed) begin
         if (sec >= 6'd59) begin
            sec_n = 6'd0;
            {min_tens_n, min_ones_n} = mstep[7:0];
            if (mstep[8]) begin
               {pm_n, hours_n} = hour_step(hours, pm);
            end
         end else begin
            sec_n = sec + 6'd1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         hours    <= 4'd12;
         pm       <= 1'b0;
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         sec      <= 6'd0;
      end else begin
         hours    <= hours_n;
         pm       <= pm_n;
         min_tens <= min_tens_n;
         min_ones <= min_ones_n;
         sec      <= sec_n;
      end
   end

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

   localparam int CLK_HZ = 10;
   localparam int DEB    = 4;
   localparam int RPT    = 20;

   logic       clk_in  = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_hr  = 1'b0;
   logic       btn_min = 1'b0;
   logic [3:0] hours, min_tens, min_ones;
   logic [5:0] sec;
   logic       pm, sec_tick;

   int n_vec = 0;
   int n_err = 0;

   time_keeper #(
      .CLK_HZ          (CLK_HZ),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_CYCLES   (RPT)
   ) dut (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .btn_hr   (btn_hr),
      .btn_min  (btn_min),
      .hours    (hours),
      .min_tens (min_tens),
      .min_ones (min_ones),
      .sec      (sec),
      .pm       (pm),
      .sec_tick (sec_tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Called on a falling edge. Hold long enough for exactly one increment
   // (visible 8 samples after press), release, let the level fall.
   task automatic press(input logic h, input logic m);
      btn_hr  = h;
      btn_min = m;
      cycles(12);
      btn_hr  = 1'b0;
      btn_min = 1'b0;
      cycles(7);
   endtask

   task automatic wait_sec(input int target, input int bound, input string tag);
      int k;
      k = 0;
      while (sec != target && k < bound) begin
         @(negedge clk_in);
         k++;
      end
      check_val(tag, sec, target);
   endtask

   task automatic check_time(input string tag, input int h, input int t,
                             input int o, input int p);
      check_val({tag, "_hours"}, hours, h);
      check_val({tag, "_tens"}, min_tens, t);
      check_val({tag, "_ones"}, min_ones, o);
      check_val({tag, "_pm"}, pm, p);
   endtask

   initial begin
      int n_tick, first_tick, last_tick, bad_gap;
      int chg_n, prev;
      int chg_at [3];

      // reset state
      cycles(3);
      check_time("rst", 12, 0, 0, 0);
      check_val("rst_sec", sec, 0);
      check_val("rst_tick", sec_tick, 0);

      // free run 600 cycles
      reset_n    = 1'b1;
      n_tick     = 0;
      first_tick = -1;
      last_tick  = -1;
      bad_gap    = 0;
      for (int s = 1; s <= 600; s++) begin
         @(negedge clk_in);
         if (sec_tick) begin
            if (first_tick < 0) first_tick = s;
            if (last_tick >= 0 && (s - last_tick) != 10) bad_gap++;
            last_tick = s;
            n_tick++;
         end
      end
      check_val("tick_count", n_tick, 60);
      check_val("tick_first", first_tick, 9);
      check_val("tick_gap_errs", bad_gap, 0);
      check_time("run600", 12, 0, 1, 0);
      check_val("run600_sec", sec, 0);

      // preload 11:59:59 AM, roll to 12:00:00 PM
      for (int i = 0; i < 11; i++) press(1'b1, 1'b0);
      check_time("set11am", 11, 0, 1, 0);
      for (int i = 0; i < 58; i++) press(1'b0, 1'b1);
      check_time("set1159", 11, 5, 9, 0);
      check_val("set1159_sec", sec, 0);
      wait_sec(59, 800, "wait_59a");
      wait_sec(0, 20, "wait_00a");
      check_time("roll12pm", 12, 0, 0, 1);

      // preload 12:59:59 PM, roll to 1:00:00 PM
      for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
      check_time("set1259", 12, 5, 9, 1);
      wait_sec(59, 800, "wait_59b");
      wait_sec(0, 20, "wait_00b");
      check_time("roll1pm", 1, 0, 0, 1);

      // bouncing minute button, then a 45-cycle hold
      for (int b = 0; b < 3; b++) begin
         btn_min = 1'b1;
         cycles(3);
         btn_min = 1'b0;
         cycles(3);
      end
      check_val("bounce_ones", min_ones, 0);
      btn_min = 1'b1;
      chg_n   = 0;
      prev    = min_ones;
      for (int s = 1; s <= 65; s++) begin
         @(negedge clk_in);
         if (s == 46) btn_min = 1'b0;
         if (s == 50) check_val("hold_sec", sec, 0);
         if (min_ones != prev) begin
            if (chg_n < 3) chg_at[chg_n] = s;
            chg_n++;
            prev = min_ones;
         end
      end
      check_val("hold_incs", chg_n, 3);
      check_val("hold_first_at", chg_at[0], 8);
      check_val("hold_rep1_gap", chg_at[1] - chg_at[0], 20);
      check_val("hold_rep2_gap", chg_at[2] - chg_at[1], 20);
      check_time("hold_end", 1, 0, 3, 1);

      // minute-set wrap does not carry into hours
      for (int i = 0; i < 56; i++) press(1'b0, 1'b1);
      check_time("min59", 1, 5, 9, 1);
      press(1'b0, 1'b1);
      check_time("min00", 1, 0, 0, 1);
      check_val("min00_sec", sec, 0);

      // hour-set through 11 PM -> 12 AM -> 11 AM -> 12 PM
      for (int i = 0; i < 10; i++) press(1'b1, 1'b0);
      check_time("h11pm", 11, 0, 0, 1);
      press(1'b1, 1'b0);
      check_time("h12am", 12, 0, 0, 0);
      for (int i = 0; i < 11; i++) press(1'b1, 1'b0);
      check_time("h11am", 11, 0, 0, 0);
      press(1'b1, 1'b0);
      check_time("h12pm", 12, 0, 0, 1);

      // simultaneous presses: hour wins, minutes untouched
      press(1'b1, 1'b1);
      check_time("both", 1, 0, 0, 1);

      // reset during auto-repeat
      btn_hr = 1'b1;
      cycles(35);
      check_val("rep_hours", hours, 3);
      reset_n = 1'b0;
      #1;
      check_time("midrst", 12, 0, 0, 0);
      check_val("midrst_sec", sec, 0);
      check_val("midrst_tick", sec_tick, 0);
      cycles(2);
      reset_n = 1'b1;
      for (int s = 1; s <= 8; s++) begin
         @(negedge clk_in);
         if (s == 7) check_val("redeb_before", hours, 12);
         if (s == 8) check_val("redeb_after", hours, 1);
      end
      check_val("redeb_pm", pm, 0);
      btn_hr = 1'b0;
      cycles(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clk_in cycles per second; prescaler terminal count is CLK_HZ-1.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive cycles a synchronized button must hold a new level before it is accepted.
REQ-003 Parameter REPEAT_CYCLES, default 25000000, hold time before and between auto-repeat increments.
REQ-004 Port clk_in  input  1  the only clock.
REQ-005 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port btn_hr  input  1  raw asynchronous hour-set button, active-high.
REQ-007 Port btn_min  input  1  raw asynchronous minute-set button, active-high.
REQ-008 Port hours  output  4  binary hour, range 1..12; feeds the digit-select/display stage.
REQ-009 Port min_tens  output  4  BCD minute tens, range 0..5.
REQ-010 Port min_ones  output  4  BCD minute ones, range 0..9.
REQ-011 Port sec  output  6  binary seconds, range 0..59.
REQ-012 Port pm  output  1  1 = PM, 0 = AM.
REQ-013 Port sec_tick  output  1  one-cycle pulse on each one-second boundary.

Function
REQ-014 Each button passes through a 2-flop synchronizer, then a debounce counter; debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level; any mismatch clears the counter.
REQ-015 Prescaler counts 0..CLK_HZ-1 and wraps; sec_tick asserts for exactly the cycle the count equals CLK_HZ-1.
REQ-016 On sec_tick: sec increments; 59 wraps to 0 with carry to minutes.
REQ-017 Minute carry: min_ones 9->0 carries to min_tens; min_tens:min_ones 5:9 -> 0:0 carries to hours.
REQ-018 Hour increment (carry or set): 12->1; 11->12 toggles pm; all other values +1.
REQ-019 Per-button set FSM states IDLE, HELD, REPEAT; all outputs registered.
REQ-020 IDLE -> HELD on debounced rising edge; exactly one increment in that transition cycle; repeat counter cleared.
REQ-021 HELD -> REPEAT after REPEAT_CYCLES cycles held, one increment on entry; in REPEAT, one increment every REPEAT_CYCLES cycles.
REQ-022 HELD or REPEAT -> IDLE on debounced falling edge, no increment.
REQ-023 Minute-set increment: min_ones/min_tens advance per REQ-017 but 59->00 does NOT carry to hours; sec cleared to 0 and prescaler cleared to 0 on every minute-set increment.
REQ-024 Hour-set increment follows REQ-018 (pm toggles on 11->12); minutes and seconds unchanged.
REQ-025 While either debounced button is pressed, prescaler held at 0, sec_tick stays 0, time does not advance.
REQ-026 Same-cycle hour-set and minute-set increments: hour applied, minute suppressed that cycle.
REQ-027 Same-cycle set increment and sec_tick (first press edge): set increment applied, tick and its carries discarded.
REQ-028 Outputs never hold out-of-range values in any cycle.

Reset
REQ-029 reset_n low asynchronously forces hours=12, min_tens=0, min_ones=0, sec=0, pm=0, sec_tick=0, prescaler=0, synchronizers/debounce state=0, both FSMs IDLE.
REQ-030 Reset asserted mid-press or mid-repeat aborts the operation; after release a still-held button must re-debounce and produce a fresh rising edge before incrementing.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20)
REQ-031 Release reset, no buttons, 600 cycles -> 60 sec_tick pulses, each 1 cycle, 10 cycles apart; time 12:01:00, pm=0.
REQ-032 Preload 11:59:59 AM via buttons, run one tick -> 12:00:00, pm=1; preload 12:59:59 -> 1:00:00, pm unchanged.
REQ-033 btn_min bouncing 3-cycle pulses then held 45 cycles -> no increment from bounces; increment at debounce, further increments at +20 and +40 cycles: 3 total; sec=0.
REQ-034 min at 59, press btn_min once -> 00, hours unchanged; hours at 11 AM, press btn_hr -> 12, pm=1.
REQ-035 Both buttons' debounced edges in same cycle -> hours +1, minutes unchanged; reset_n pulsed low during REPEAT -> all outputs at reset values immediately, no increment until re-debounced press.
